// File: rtl/buffer_ring_ctl.sv
// buffer_ring_ctl
//   Sequencer and round-robin arbiter for a two-digit buffer address ring made
//   of two external 2-of-5 decade counters (units, tens). Each granted step
//   pulses the units counter's advance, adds a tens advance on a 9->0 carry,
//   and wraps the ring to 00 through a clear once the position reaches LAST.
//
// Parameters
//   LAST    last valid buffer position (0..99); stepping from LAST returns to 00
//   CHK_EN  enables the sticky 2-of-5 validity error latch
//
// Ports
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_req_a, i_req_b      step requests (channel side A, device side B)
//   o_ack_a, o_ack_b      one-cycle step-complete pulses
//   o_wrap                qualified by an ack: that step wrapped LAST->00
//   i_units, i_tens       counter codes {a,b,c,d,e}
//   o_units_adv           units counter advance (counter steps on 0->1)
//   o_tens_adv            tens counter advance
//   o_ring_clear          clear to both counters (forces code 00011)
//   o_addr                current position in binary, 0 when a digit is invalid
//   o_busy                step in progress (low only in IDLE)
//   o_check               sticky invalid-code error, cleared only by reset
//   o_state               FSM state, for observation
//
// Handshake: a requester raises req and holds it until it sees its one-cycle
// ack; the step is committed once granted in IDLE and always completes with
// an ack. A req still high after its ack counts as a new request.

module buffer_ring_ctl #(
    parameter int LAST   = 79,
    parameter bit CHK_EN = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_req_a,
    input  logic       i_req_b,
    output logic       o_ack_a,
    output logic       o_ack_b,
    output logic       o_wrap,
    input  logic [4:0] i_units,
    input  logic [4:0] i_tens,
    output logic       o_units_adv,
    output logic       o_tens_adv,
    output logic       o_ring_clear,
    output logic [6:0] o_addr,
    output logic       o_busy,
    output logic       o_check,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        S_CLR  = 3'd0,
        S_IDLE = 3'd1,
        S_UADV = 3'd2,
        S_USET = 3'd3,
        S_TADV = 3'd4,
        S_TSET = 3'd5,
        S_DONE = 3'd6
    } state_t;

    localparam logic [6:0] LAST_ADDR = 7'(LAST);
    localparam logic [4:0] CODE_NINE = 5'b00101;

    state_t state;
    logic   gnt_b;    // granted requester: 1 = B, 0 = A
    logic   carry;    // units was 9 when the step was granted
    logic   wrap_q;   // current step wraps LAST->00
    logic   rr_b;     // round-robin pointer: 1 = favour B on a tie

    // Returns {valid, digit}; anything outside the 2-of-5 table is invalid.
    function automatic logic [4:0] decode(input logic [4:0] code);
        case (code)
            5'b00011: decode = {1'b1, 4'd0};
            5'b10010: decode = {1'b1, 4'd1};
            5'b10001: decode = {1'b1, 4'd2};
            5'b01001: decode = {1'b1, 4'd3};
            5'b11000: decode = {1'b1, 4'd4};
            5'b10100: decode = {1'b1, 4'd5};
            5'b01100: decode = {1'b1, 4'd6};
            5'b01010: decode = {1'b1, 4'd7};
            5'b00110: decode = {1'b1, 4'd8};
            5'b00101: decode = {1'b1, 4'd9};
            default:  decode = {1'b0, 4'd0};
        endcase
    endfunction

    logic [4:0] u_dec;
    logic [4:0] t_dec;
    logic       codes_ok;
    logic       grant_b;

    always_comb begin
        u_dec    = decode(i_units);
        t_dec    = decode(i_tens);
        codes_ok = u_dec[4] & t_dec[4];
        o_addr   = 7'd0;
        if (codes_ok)
            o_addr = {3'b000, t_dec[3:0]} * 7'd10 + {3'b000, u_dec[3:0]};
        // A lone request wins outright; on a tie the pointer decides.
        grant_b  = i_req_b & (~i_req_a | rr_b);
    end

    assign o_state = state;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= S_CLR;
            o_ring_clear <= 1'b1;
            o_units_adv  <= 1'b0;
            o_tens_adv   <= 1'b0;
            o_ack_a      <= 1'b0;
            o_ack_b      <= 1'b0;
            o_wrap       <= 1'b0;
            o_busy       <= 1'b1;
            o_check      <= 1'b0;
            rr_b         <= 1'b0;
            gnt_b        <= 1'b0;
            carry        <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            // Pulsed outputs default low; states below raise them for one cycle.
            o_ring_clear <= 1'b0;
            o_units_adv  <= 1'b0;
            o_tens_adv   <= 1'b0;
            o_ack_a      <= 1'b0;
            o_ack_b      <= 1'b0;
            o_wrap       <= 1'b0;

            if (CHK_EN && (state == S_IDLE || state == S_DONE) && !codes_ok)
                o_check <= 1'b1;

            case (state)
                S_CLR: begin
                    // Only a wrap step reaches CLR with wrap_q set; the
                    // reset-time clear returns to IDLE without an ack.
                    if (wrap_q) begin
                        state   <= S_DONE;
                        o_ack_a <= ~gnt_b;
                        o_ack_b <= gnt_b;
                        o_wrap  <= 1'b1;
                    end else begin
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (i_req_a || i_req_b) begin
                        gnt_b  <= grant_b;
                        carry  <= (i_units == CODE_NINE);
                        wrap_q <= (o_addr == LAST_ADDR);
                        o_busy <= 1'b1;
                        if (o_addr == LAST_ADDR) begin
                            state        <= S_CLR;
                            o_ring_clear <= 1'b1;
                        end else begin
                            state       <= S_UADV;
                            o_units_adv <= 1'b1;
                        end
                    end
                end
                S_UADV: state <= S_USET;
                S_USET: begin
                    if (carry) begin
                        state      <= S_TADV;
                        o_tens_adv <= 1'b1;
                    end else begin
                        state   <= S_DONE;
                        o_ack_a <= ~gnt_b;
                        o_ack_b <= gnt_b;
                        o_wrap  <= wrap_q;
                    end
                end
                S_TADV: state <= S_TSET;
                S_TSET: begin
                    state   <= S_DONE;
                    o_ack_a <= ~gnt_b;
                    o_ack_b <= gnt_b;
                    o_wrap  <= wrap_q;
                end
                S_DONE: begin
                    rr_b   <= ~gnt_b;
                    wrap_q <= 1'b0;
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state        <= S_CLR;
                    o_ring_clear <= 1'b1;
                    o_busy       <= 1'b1;
                    wrap_q       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/buffer_ring_ctl.md
Name: buffer_ring_ctl

Overview:
- Sequencer and arbiter for a two-digit buffer address ring built from two external 2-of-5 decade counters (units, tens).
- Two requesters share the ring: channel side (A) and device side (B). The block grants one at a time and pulses the counters' advance inputs, including tens carry.
- Wraps the ring at a programmable last position, checks both codes for 2-of-5 validity, and presents the position in binary.

Parameters:
- LAST, 79, last valid buffer position (0..99); stepping from LAST returns to 00.
- CHK_EN, 1, enables the 2-of-5 validity check and error latch.

Ports:
- i_clk  input  1  clock
- i_reset  input  1  synchronous active-high reset
- i_req_a  input  1  channel-side step request; level, held until ack
- i_req_b  input  1  device-side step request; level, held until ack
- o_ack_a  output  1  one-cycle step-complete pulse to A
- o_ack_b  output  1  one-cycle step-complete pulse to B
- o_wrap  output  1  valid with ack: this step wrapped LAST->00
- i_units  input  5  units counter code {a,b,c,d,e}
- i_tens  input  5  tens counter code {a,b,c,d,e}
- o_units_adv  output  1  advance to units counter (counter steps on 0->1 edge)
- o_tens_adv  output  1  advance to tens counter
- o_ring_clear  output  1  clear to both counters (forces code 00011 = "0")
- o_addr  output  7  current position, binary 0..99
- o_busy  output  1  step in progress
- o_check  output  1  sticky code-invalid error; cleared only by reset

Behaviour:
- Code table: 10010=1, 10001=2, 01001=3, 11000=4, 10100=5, 01100=6, 01010=7, 00110=8, 00101=9, 00011=0. A code is valid iff it is in this table.
- o_addr = 10*tens + units, combinational from the inputs. Any invalid digit gives o_addr = 0.
- Reset:
  - FSM goes to CLR and all acks are 0.
  - o_check = 0, o_wrap = 0, o_busy = 1, adv outputs = 0.
  - CLR asserts o_ring_clear for one cycle, then goes to IDLE.
- Counter latency: a counter's code updates on the clock edge after the cycle its adv input rises. Adv must be low for at least one cycle between pulses.
- States: CLR, IDLE, UADV, USET, TADV, TSET, DONE.
- IDLE:
  - o_busy = 0.
  - If any request is pending, arbitrate round-robin. The pointer favours the requester not granted last; after reset it favours A.
  - Latch the grant and carry = (units code == 9), then go to UADV.
  - Latch wrap = (o_addr == LAST). If wrap, skip UADV and go to CLR (ack issued after clear; see below).
- UADV: o_units_adv = 1 for one cycle -> USET.
- USET: adv = 0; the new units code is visible. If carry -> TADV, else -> DONE.
- TADV: o_tens_adv = 1 for one cycle -> TSET.
- TSET: adv = 0 -> DONE.
- DONE:
  - Pulse the ack of the granted requester for one cycle, with o_wrap = latched wrap.
  - Update the round-robin pointer, then -> IDLE.
  - A requester that still holds req after its ack is treated as a new request.
- Wrap path: IDLE -> CLR (o_ring_clear 1 cycle) -> DONE with o_wrap = 1. CLR entered from reset issues no ack.
- Throughput:
  - Non-carry step: req seen in IDLE -> ack 3 cycles later (UADV, USET, DONE).
  - Carry step: ack 5 cycles later.
  - Wrap step: ack 2 cycles later.
- Simultaneous requests: exactly one is granted; the other is granted next, with no request starved.
- Request dropped before ack: not allowed (protocol violation); the step still completes and the ack is still issued.
- Check (CHK_EN = 1): in IDLE and DONE, if either code is invalid, set o_check. Stepping continues regardless.
- Counter codes are not compared against expected values; only validity is checked.
- i_reset mid-step:
  - Abandons the step with no ack.
  - Drops adv on the same edge, then clears the ring via CLR.
  - Pointer returns to A.

Test Plan:
- Reset, then hold i_req_a: o_ring_clear pulses once, o_addr = 0. Each ack advances o_addr by 1. The ack for 9->10 arrives 5 cycles after the request is seen; others arrive after 3.
- Step from 79 with LAST = 79: o_ring_clear pulses, ack with o_wrap = 1, units = 00011, tens = 00011, o_addr = 0.
- i_req_a and i_req_b asserted together and held for 6 steps: acks alternate A, B, A, B, A, B, starting with A.
- Force i_units = 00111 in IDLE: o_check = 1 and stays 1 after the code is restored. Only i_reset clears it.
- Assert i_reset during TADV: adv outputs are 0 next cycle, no ack, o_ring_clear pulses, o_addr = 0.
- LAST = 99 with 100 steps from 0: exactly one o_wrap, on step 100; o_addr returns to 0.
